// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller:
// segment table, blank pattern and counter-width helpers.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low cathode patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width of a counter holding 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Widths for the default build (200k ticks, 8 digits, 64 frames)
  localparam int TICK_W  = $clog2(200_000);
  localparam int DIGIT_W = $clog2(8);
  localparam int FRAME_W = $clog2(64);

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Bus between the datapath and the display driver:
// digit data/attributes in, cathode/anode pins out.
interface ssd_scan_controller_if #(
  parameter int NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] ssd_scan_controller_data_in;
  logic [NUM_DIGITS-1:0]   ssd_scan_controller_dp_in;
  logic [NUM_DIGITS-1:0]   ssd_scan_controller_digit_en;
  logic [NUM_DIGITS-1:0]   ssd_scan_controller_blink_en;
  logic                    ssd_scan_controller_lz_blank;
  logic [3:0]              ssd_scan_controller_brightness;
  logic [6:0]              ssd_scan_controller_oport_cc;
  logic                    ssd_scan_controller_oport_dp;
  logic [NUM_DIGITS-1:0]   ssd_scan_controller_oport_anode_control;
  logic                    ssd_scan_controller_frame_pulse;

  modport master (
    output ssd_scan_controller_data_in,
    output ssd_scan_controller_dp_in,
    output ssd_scan_controller_digit_en,
    output ssd_scan_controller_blink_en,
    output ssd_scan_controller_lz_blank,
    output ssd_scan_controller_brightness,
    input  ssd_scan_controller_oport_cc,
    input  ssd_scan_controller_oport_dp,
    input  ssd_scan_controller_oport_anode_control,
    input  ssd_scan_controller_frame_pulse
  );

  modport slave (
    input  ssd_scan_controller_data_in,
    input  ssd_scan_controller_dp_in,
    input  ssd_scan_controller_digit_en,
    input  ssd_scan_controller_blink_en,
    input  ssd_scan_controller_lz_blank,
    input  ssd_scan_controller_brightness,
    output ssd_scan_controller_oport_cc,
    output ssd_scan_controller_oport_dp,
    output ssd_scan_controller_oport_anode_control,
    output ssd_scan_controller_frame_pulse
  );

endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low
// seven-segment cathode pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scanner with frame snapshot,
// blanking, PWM dimming, blink and leading-zero suppression.
module ssd_scan_controller #(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 200_000,
  parameter int BLANK_TICKS     = 2_000,
  parameter int BLINK_FRAMES    = 64
) (
  input logic ssd_scan_controller_clk,
  input logic ssd_scan_controller_rst,
  ssd_scan_controller_if.slave bus
);

  import ssd_pkg::*;

  localparam int TW = cnt_w(TICKS_PER_DIGIT);
  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int FW = cnt_w(BLINK_FRAMES);

  localparam logic [TW-1:0] T_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_TICKS);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic clk;
  logic rst;
  assign clk = ssd_scan_controller_clk;
  assign rst = ssd_scan_controller_rst;

  logic [TW-1:0] tick;
  logic [IW-1:0] idx;
  logic [3:0]    pwm;
  logic [FW-1:0] frm;
  logic          phase;

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;
  logic [3:0]              sh_bright;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   lz_nxt;

  logic [NUM_DIGITS-1:0] anode_q;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic [6:0]            cc_q;
  logic                  dp_q;
  logic                  fp_q;

  logic       frame_start;
  logic       tick_wrap;
  logic       frame_end;
  logic       blanking;
  logic [3:0] pwm_cur;
  logic       pwm_on;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] seg;

  logic [3:0] nib [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = sh_data[4*g +: 4];
  end

  assign frame_start = (tick == '0) && (idx == '0);
  assign tick_wrap   = (tick == T_LAST);
  assign frame_end   = tick_wrap && (idx == I_LAST);
  assign blanking    = (tick < T_BLANK);
  // The PWM phase restarts with each digit's active window
  assign pwm_cur     = (tick == T_BLANK) ? 4'd0 : pwm;
  assign pwm_on      = (pwm_cur <= sh_bright);
  assign nibble      = nib[idx];
  assign lit         = ~&anode_nxt;

  ssd_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

  // Scan, PWM and blink counters
  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= '0;
      idx   <= '0;
      pwm   <= '0;
      frm   <= '0;
      phase <= 1'b0;
    end else begin
      tick <= tick_wrap ? '0 : tick + TW'(1);
      pwm  <= pwm_cur + 4'd1;
      if (tick_wrap) begin
        idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
      end
      if (frame_end) begin
        if (frm == F_LAST) begin
          frm   <= '0;
          phase <= ~phase;
        end else begin
          frm <= frm + FW'(1);
        end
      end
    end
  end

  // Frame snapshot of all inputs, plus the derived zero mask
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
      sh_bright <= '0;
      lz_mask   <= '0;
    end else begin
      lz_mask <= lz_nxt;
      if (frame_start) begin
        sh_data   <= bus.ssd_scan_controller_data_in;
        sh_dp     <= bus.ssd_scan_controller_dp_in;
        sh_en     <= bus.ssd_scan_controller_digit_en;
        sh_blink  <= bus.ssd_scan_controller_blink_en;
        sh_lz     <= bus.ssd_scan_controller_lz_blank;
        sh_bright <= bus.ssd_scan_controller_brightness;
      end
    end
  end

  // Mask zeros from the top digit down; digit 0 always shows
  always_comb begin
    logic seen;
    seen   = 1'b0;
    lz_nxt = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (nib[i] != 4'd0) seen = 1'b1;
      lz_nxt[i] = sh_lz & ~seen;
    end
  end

  // Anode select with blank, PWM, enable, mask and blink gating
  always_comb begin
    anode_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((idx == IW'(i)) && !blanking && pwm_on &&
          sh_en[i] && !lz_mask[i] &&
          !(phase && sh_blink[i])) begin
        anode_nxt[i] = 1'b0;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q <= '1;
      cc_q    <= SEG_OFF;
      dp_q    <= 1'b1;
      fp_q    <= 1'b0;
    end else begin
      anode_q <= anode_nxt;
      cc_q    <= lit ? seg : SEG_OFF;
      dp_q    <= lit ? ~sh_dp[idx] : 1'b1;
      fp_q    <= frame_start;
    end
  end

  assign bus.ssd_scan_controller_oport_anode_control = anode_q;
  assign bus.ssd_scan_controller_oport_cc            = cc_q;
  assign bus.ssd_scan_controller_oport_dp            = dp_q;
  assign bus.ssd_scan_controller_frame_pulse         = fp_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller: 4 digits,
// 32 ticks per slot, 4 blank ticks, 2 frames per blink half.
module tb_ssd_scan_controller;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ssd_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_controller #(
    .NUM_DIGITS      (ND),
    .TICKS_PER_DIGIT (32),
    .BLANK_TICKS     (4),
    .BLINK_FRAMES    (2)
  ) dut (
    .ssd_scan_controller_clk (clk),
    .ssd_scan_controller_rst (rst),
    .bus                     (bus.slave)
  );

  always #5 clk = ~clk;

  logic [3:0] an;
  logic [6:0] cc;
  logic       dp;
  logic       fp;
  assign an = bus.ssd_scan_controller_oport_anode_control;
  assign cc = bus.ssd_scan_controller_oport_cc;
  assign dp = bus.ssd_scan_controller_oport_dp;
  assign fp = bus.ssd_scan_controller_frame_pulse;

  // cnt = scan count whose registered outputs are now visible
  int cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic go(input int k);
    while (cnt < k) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea,
                         input logic [6:0] ec, input logic ed);
    chk({tag, ".an"}, 32'(an), 32'(ea));
    chk({tag, ".cc"}, 32'(cc), 32'(ec));
    chk({tag, ".dp"}, 32'(dp), 32'(ed));
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dpi,
                        input logic [3:0] en, input logic [3:0] bl,
                        input logic lz, input logic [3:0] br);
    bus.ssd_scan_controller_data_in    = d;
    bus.ssd_scan_controller_dp_in      = dpi;
    bus.ssd_scan_controller_digit_en   = en;
    bus.ssd_scan_controller_blink_en   = bl;
    bus.ssd_scan_controller_lz_blank   = lz;
    bus.ssd_scan_controller_brightness = br;
  endtask

  initial begin
    set_in(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15);

    // Reset held for three edges
    step();
    chk_out("rst1", 4'hF, 7'h7F, 1'b1);
    chk("rst1.fp", 32'(fp), 32'd0);
    step();
    step();
    chk_out("rst3", 4'hF, 7'h7F, 1'b1);
    chk("rst3.fp", 32'(fp), 32'd0);
    rst = 1'b0;
    cnt = -1;

    // Frame 0: data 12AF, full brightness
    go(0);
    chk("fp0", 32'(fp), 32'd1);
    go(1);
    chk("fp1", 32'(fp), 32'd0);
    go(3);
    chk_out("blank0", 4'hF, 7'h7F, 1'b1);
    go(4);
    chk_out("s0.t4", 4'b1110, 7'h0E, 1'b1);
    go(31);
    chk_out("s0.t31", 4'b1110, 7'h0E, 1'b1);
    go(35);
    chk_out("s1.blank", 4'hF, 7'h7F, 1'b1);
    go(36);
    chk_out("s1.t4", 4'b1101, 7'h08, 1'b1);
    go(100);
    chk_out("s3.t4", 4'b0111, 7'h79, 1'b1);
    go(127);
    chk_out("s3.t31", 4'b0111, 7'h79, 1'b1);
    chk("fp127", 32'(fp), 32'd0);

    // Frame 1: leading zeros suppressed on 0050
    set_in(16'h0050, 4'h0, 4'hF, 4'h0, 1'b1, 4'd15);
    go(128);
    chk("fp128", 32'(fp), 32'd1);
    go(132);
    chk_out("lz.d0", 4'b1110, 7'h40, 1'b1);
    go(164);
    chk_out("lz.d1", 4'b1101, 7'h12, 1'b1);
    go(196);
    chk_out("lz.d2", 4'hF, 7'h7F, 1'b1);
    go(228);
    chk_out("lz.d3", 4'hF, 7'h7F, 1'b1);

    // Frame 2: all zeros, only digit 0 lit
    set_in(16'h0000, 4'h0, 4'hF, 4'h0, 1'b1, 4'd15);
    go(256);
    chk("fp256", 32'(fp), 32'd1);
    go(260);
    chk_out("z.d0", 4'b1110, 7'h40, 1'b1);
    go(292);
    chk_out("z.d1", 4'hF, 7'h7F, 1'b1);
    go(356);
    chk_out("z.d3", 4'hF, 7'h7F, 1'b1);

    // Frame 3: brightness 3 -> on 4 of each 16 window cycles
    set_in(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0, 4'd3);
    go(388);
    chk("pwm.t4", 32'(an), 32'h0E);
    go(391);
    chk("pwm.t7", 32'(an), 32'h0E);
    go(392);
    chk_out("pwm.t8", 4'hF, 7'h7F, 1'b1);
    go(403);
    chk("pwm.t19", 32'(an), 32'h0F);
    go(404);
    chk("pwm.t20", 32'(an), 32'h0E);
    go(407);
    chk("pwm.t23", 32'(an), 32'h0E);
    go(408);
    chk("pwm.t24", 32'(an), 32'h0F);

    // Frames 4..8: digit 0 blinks, two frames per half period
    set_in(16'h12AF, 4'h0, 4'hF, 4'h1, 1'b0, 4'd15);
    go(516);
    chk("blink.f4", 32'(an), 32'h0E);
    go(644);
    chk("blink.f5", 32'(an), 32'h0E);
    go(772);
    chk("blink.f6", 32'(an), 32'h0F);
    go(804);
    chk("blink.f6.d1", 32'(an), 32'h0D);
    go(900);
    chk("blink.f7", 32'(an), 32'h0F);
    go(1028);
    chk("blink.f8", 32'(an), 32'h0E);

    // Frame 9: digit 2 disabled, decimal point on digit 1
    go(1151);
    set_in(16'h12AF, 4'b0010, 4'b1011, 4'h0, 1'b0, 4'd15);
    go(1156);
    chk_out("en.d0", 4'b1110, 7'h0E, 1'b1);
    go(1188);
    chk_out("en.d1", 4'b1101, 7'h08, 1'b0);
    go(1220);
    chk_out("en.d2", 4'hF, 7'h7F, 1'b1);
    go(1252);
    chk_out("en.d3", 4'b0111, 7'h79, 1'b1);

    // Frame 10: input change mid-frame stays invisible
    go(1279);
    set_in(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15);
    go(1321);
    set_in(16'h3456, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15);
    go(1330);
    chk_out("tear.d1", 4'b1101, 7'h08, 1'b1);
    go(1380);
    chk_out("tear.d3", 4'b0111, 7'h79, 1'b1);
    go(1408);
    chk("fp1408", 32'(fp), 32'd1);
    go(1412);
    chk_out("new.d0", 4'b1110, 7'h02, 1'b1);
    go(1508);
    chk_out("new.d3", 4'b0111, 7'h30, 1'b1);

    // Frame 12: reset at tick 20 of slot 2
    go(1619);
    chk_out("pre.rst", 4'b1011, 7'h19, 1'b1);
    rst = 1'b1;
    set_in(16'h0007, 4'h0, 4'hF, 4'h0, 1'b0, 4'd15);
    step();
    chk_out("mid.rst", 4'hF, 7'h7F, 1'b1);
    chk("mid.rst.fp", 32'(fp), 32'd0);
    step();
    rst = 1'b0;
    cnt = -1;
    go(0);
    chk("re.fp0", 32'(fp), 32'd1);
    go(3);
    chk("re.blank", 32'(an), 32'h0F);
    go(4);
    chk_out("re.d0", 4'b1110, 7'h78, 1'b1);
    go(36);
    chk_out("re.d1", 4'b1101, 7'h40, 1'b1);
    go(128);
    chk("re.fp128", 32'(fp), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 8-digit hex scanner and drives NUM_DIGITS common-anode digits from a packed nibble bus. New over the previous generation:
- tear-free frame snapshot of all inputs
- inter-digit blanking (anti-ghosting)
- 16-level brightness PWM
- per-digit enable and blink
- optional leading-zero suppression
- decimal points
- frame strobe
It sits between the FIFO/status datapath and the board's cathode/anode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16).
- TICKS_PER_DIGIT, 200_000, clock cycles per digit slot.
- BLANK_TICKS, 2_000, cycles at the start of each slot with all anodes off. Must satisfy 2 <= BLANK_TICKS < TICKS_PER_DIGIT.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1).

Ports:
- ssd_scan_controller_clk  in  1  system clock (100 MHz).
- ssd_scan_controller_rst  in  1  synchronous reset, active-high.
- ssd_scan_controller_data_in  in  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i].
- ssd_scan_controller_dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- ssd_scan_controller_digit_en  in  NUM_DIGITS  1 = digit may light.
- ssd_scan_controller_blink_en  in  NUM_DIGITS  1 = digit blinks.
- ssd_scan_controller_lz_blank  in  1  1 = suppress leading zeros.
- ssd_scan_controller_brightness  in  4  duty level, 0 = 1/16 … 15 = 16/16.
- ssd_scan_controller_oport_cc  out  7  cathodes, active-low, bit6 = g … bit0 = a.
- ssd_scan_controller_oport_dp  out  1  decimal-point cathode, active-low.
- ssd_scan_controller_oport_anode_control  out  NUM_DIGITS  anodes, active-low, bit i = digit i.
- ssd_scan_controller_frame_pulse  out  1  one-cycle strobe at each frame start.

Behaviour:
- Reset: one clock and a synchronous active-high reset. During and at reset:
  - anodes all 1, cc = 7'h7F, dp = 1, frame_pulse = 0
  - tick = 0, digit index = 0, pwm = 0, frame counter = 0, blink phase = 0, shadow registers = 0
  - Reset asserted mid-operation forces these values on the next edge; the scan restarts at digit 0.
- Scan:
  - tick counts 0..TICKS_PER_DIGIT-1.
  - At the terminal count, tick goes to 0 and the index advances, wrapping NUM_DIGITS-1 -> 0.
  - Frame start is the cycle with tick == 0 and index == 0, including the first cycle after reset release.
- Snapshot:
  - At frame start, data_in, dp_in, digit_en, blink_en, lz_blank and brightness are latched into shadow registers.
  - The display uses only shadow values, so input changes mid-frame are invisible until the next frame.
- frame_pulse is high for exactly the frame-start cycle. Period = NUM_DIGITS*TICKS_PER_DIGIT.
- Leading-zero mask:
  - Registered one cycle after the snapshot; this is covered by the blank phase.
  - When lz_blank = 1, digits from NUM_DIGITS-1 downward with nibble 0 are masked until the first nonzero nibble.
  - Digit 0 is never masked.
- Blink:
  - The frame counter counts 0..BLINK_FRAMES-1; blink phase toggles on each wrap.
  - When phase = 1, digits with blink_en set are dark.
- Blank phase: while tick < BLANK_TICKS, anodes are all 1 and cc/dp are all 1.
- PWM:
  - A 4-bit counter is cleared at tick == BLANK_TICKS and then free-runs.
  - pwm_on = (pwm <= brightness).
- Anode i is low iff all of the following hold:
  - index == i
  - tick >= BLANK_TICKS
  - pwm_on
  - digit_en[i]
  - not lz-masked
  - not (blink phase and blink_en[i])
- When the anode is low, cc = hex pattern of the nibble and dp = ~dp_in[i]. Otherwise cc and dp are all 1.
- Hex patterns, 0..F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex of 7-bit cc).
- Latency: all outputs are registered, one cycle after the tick/index state that produces them. No X or Z is ever driven.

Decomposition:
- Shared package ssd_pkg holds:
  - the 16-entry hex-to-segment constant table
  - SEG_OFF = 7'h7F
  - localparams for counter widths ($clog2 of TICKS_PER_DIGIT, NUM_DIGITS, BLINK_FRAMES)
- One natural sub-module: ssd_hex_decoder, a combinational nibble -> 7-bit cc using the package table.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, TICKS_PER_DIGIT=32, BLANK_TICKS=4, BLINK_FRAMES=2.
1. Reset: hold rst for 3 cycles, then release -> anodes 4'b1111, cc 7'h7F, dp 1, frame_pulse 0 during reset; frame_pulse high on the first cycle after release, then every 128 cycles.
2. Basic scan: data 16'h12AF, en 4'hF, brightness 15, lz 0 -> slot 0, cycles 5..32 after frame start: anode 1110, cc 7'h0E. Slot 3: anode 0111, cc 7'h79. All anodes 1 for the first 4 cycles of every slot.
3. Leading zeros: data 16'h0050, lz 1 -> digits 3 and 2 never lit; digit 1 cc 7'h12; digit 0 cc 7'h40. Data 16'h0000 -> only digit 0 lit, showing 7'h40.
4. Brightness: brightness 3 -> in every active window, the anode is low for exactly 4 of each 16 cycles, aligned to the window start. Brightness 15 -> low for all 28 cycles.
5. Blink and enable: blink_en 4'b0001 -> digit 0 lit in frames 0–1, dark in frames 2–3, lit in frames 4–5. digit_en 4'b1011 -> digit 2 never lit. dp_in 4'b0010 -> dp = 0 only in slot 1.
6. Tear-free and mid-reset: change data at tick 10 of slot 1 -> output unchanged until the next frame_pulse. Assert rst at tick 20 of slot 2 -> outputs off on the next edge; after release, the scan resumes at digit 0 with a fresh snapshot.
